// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor computing Diff = A - B - Bin, LSB first
//
// One add cell plus a registered carry computes A + ~B + ~Bin, one bit per
// clock. The operation is started with a start/done handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, accepted only in IDLE or DONE
//   A, B   minuend / subtrahend (WIDTH bits), captured on accept
//   Bin    borrow in, captured on accept
//   busy   high while bits are being processed
//   done   one-cycle pulse; results valid from this cycle
//   Diff   registered difference
//   Bout   borrow out (A < B + Bin, unsigned)
//   Ovf    signed overflow of A - B - Bin
//   Zero   Diff == 0
module serial_subtractor #(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    cnt;
    logic             carry;
    // Operand sign bits are shifted out of a_sh/b_sh, so keep them for Ovf.
    logic             a_msb;
    logic             b_msb;

    logic             b_inv;
    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] r_next;

    always_comb begin
        b_inv  = ~b_sh[0];
        s      = a_sh[0] ^ b_inv ^ carry;
        c_next = (a_sh[0] & b_inv) | (a_sh[0] & carry) | (b_inv & carry);
        r_next = {s, r_sh[WIDTH-1:1]};
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
            Ovf   <= 1'b0;
            Zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        r_sh  <= '0;
                        cnt   <= '0;
                        // Subtraction as A + ~B + 1 - Bin: initial carry is ~Bin.
                        carry <= ~Bin;
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    carry <= c_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // s is the MSB of the finished result here.
                        Diff  <= r_next;
                        Bout  <= ~c_next;
                        Ovf   <= (a_msb != b_msb) && (s != a_msb);
                        Zero  <= (r_next == '0);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
